// File: rtl/uart_label_writer.sv
// Converts a UART byte stream into label RAM writes, with escape sequences
// that reposition the cursor and a form-feed byte that sweeps the RAM clear.
module uart_label_writer #(
  parameter int unsigned ADDR_W     = 8,
  parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr,
  input  logic [7:0]        i_data,
  input  logic              i_flag_clr,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [7:0]        o_din,
  output logic [ADDR_W-1:0] o_cursor,
  output logic              o_busy,
  output logic              o_err,
  output logic              o_overrun
);

  localparam logic [7:0]        BYTE_ESC  = 8'h1B;
  localparam logic [7:0]        BYTE_FF   = 8'h0C;
  localparam logic [7:0]        BYTE_SETA = 8'h41;
  localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ESC,
    S_SETADDR,
    S_CLEAR
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cursor;
  logic [ADDR_W-1:0]   r_sweep;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_din;
  logic                r_busy;
  logic                r_err;
  logic                r_overrun;

  state_t              w_state_n;
  logic [ADDR_W-1:0]   w_cursor_n;
  logic [ADDR_W-1:0]   w_sweep_n;
  logic                w_we_n;
  logic [ADDR_W-1:0]   w_addr_n;
  logic [7:0]          w_din_n;
  logic                w_busy_n;
  logic                w_err_n;
  logic                w_overrun_n;
  logic                w_err_set;
  logic                w_overrun_set;

  // State and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cursor  <= '0;
      r_sweep   <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_din     <= 8'h00;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_cursor  <= w_cursor_n;
      r_sweep   <= w_sweep_n;
      r_we      <= w_we_n;
      r_addr    <= w_addr_n;
      r_din     <= w_din_n;
      r_busy    <= w_busy_n;
      r_err     <= w_err_n;
      r_overrun <= w_overrun_n;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    w_state_n     = r_state;
    w_cursor_n    = r_cursor;
    w_sweep_n     = r_sweep;
    w_we_n        = 1'b0;
    w_addr_n      = r_addr;
    w_din_n       = r_din;
    w_err_set     = 1'b0;
    w_overrun_set = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (i_wr) begin
          if (i_data == BYTE_ESC) begin
            w_state_n = S_ESC;
          end else if (i_data == BYTE_FF) begin
            // First sweep write is issued on the entry edge itself
            w_state_n = S_CLEAR;
            w_sweep_n = '0;
            w_we_n    = 1'b1;
            w_addr_n  = '0;
            w_din_n   = CLEAR_CHAR;
          end else begin
            w_we_n     = 1'b1;
            w_addr_n   = r_cursor;
            w_din_n    = i_data;
            w_cursor_n = r_cursor + ADDR_W'(1);
          end
        end
      end

      S_ESC: begin
        if (i_wr) begin
          w_state_n = S_IDLE;
          if (i_data == BYTE_SETA) begin
            w_state_n = S_SETADDR;
          end else if (i_data == BYTE_ESC) begin
            w_we_n     = 1'b1;
            w_addr_n   = r_cursor;
            w_din_n    = BYTE_ESC;
            w_cursor_n = r_cursor + ADDR_W'(1);
          end else begin
            w_err_set = 1'b1;
          end
        end
      end

      S_SETADDR: begin
        if (i_wr) begin
          w_cursor_n = ADDR_W'(i_data);
          w_state_n  = S_IDLE;
        end
      end

      S_CLEAR: begin
        w_overrun_set = i_wr;
        if (r_sweep == ADDR_MAX) begin
          w_state_n  = S_IDLE;
          w_cursor_n = '0;
        end else begin
          w_sweep_n = r_sweep + ADDR_W'(1);
          w_we_n    = 1'b1;
          w_addr_n  = r_sweep + ADDR_W'(1);
          w_din_n   = CLEAR_CHAR;
        end
      end

      default: w_state_n = S_IDLE;
    endcase

    w_busy_n    = (w_state_n == S_CLEAR);
    // Setting a sticky flag wins over a simultaneous clear request
    w_err_n     = w_err_set | (r_err & ~i_flag_clr);
    w_overrun_n = w_overrun_set | (r_overrun & ~i_flag_clr);
  end

  assign o_we      = r_we;
  assign o_addr    = r_addr;
  assign o_din     = r_din;
  assign o_cursor  = r_cursor;
  assign o_busy    = r_busy;
  assign o_err     = r_err;
  assign o_overrun = r_overrun;

endmodule

// File: tb/tb_uart_label_writer.sv
// Self-checking bench for uart_label_writer: directed scenarios followed by
// randomized byte streams compared against a byte-level behavioural model.
module tb_uart_label_writer;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_wr;
  logic [7:0] i_data;
  logic       i_flag_clr;
  logic       o_we;
  logic [7:0] o_addr;
  logic [7:0] o_din;
  logic [7:0] o_cursor;
  logic       o_busy;
  logic       o_err;
  logic       o_overrun;

  int total = 0;
  int bad   = 0;

  // Model: 0 = plain text, 1 = after ESC, 2 = awaiting address byte
  int         m_mode;
  logic [7:0] m_cursor;
  logic       m_err;
  logic       m_ovr;

  uart_label_writer #(.ADDR_W(8), .CLEAR_CHAR(8'h20)) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_wr       (i_wr),
    .i_data     (i_data),
    .i_flag_clr (i_flag_clr),
    .o_we       (o_we),
    .o_addr     (o_addr),
    .o_din      (o_din),
    .o_cursor   (o_cursor),
    .o_busy     (o_busy),
    .o_err      (o_err),
    .o_overrun  (o_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_mode   = 0;
    m_cursor = 8'h00;
    m_err    = 1'b0;
    m_ovr    = 1'b0;
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_cursor"}, 32'(o_cursor), 32'(m_cursor));
    chk({tag, "_err"}, 32'(o_err), 32'(m_err));
    chk({tag, "_ovr"}, 32'(o_overrun), 32'(m_ovr));
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    model_reset();
    chk("rst_we", 32'(o_we), 32'd0);
    chk("rst_addr", 32'(o_addr), 32'd0);
    chk("rst_din", 32'(o_din), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk_flags("rst");
  endtask

  // Expects the sweep entry edge to have just passed; optional overrun strobe at step ovr_k
  task automatic sweep(input int ovr_k);
    chk("clr_we0", 32'(o_we), 32'd1);
    chk("clr_addr0", 32'(o_addr), 32'd0);
    chk("clr_din0", 32'(o_din), 32'h20);
    chk("clr_busy0", 32'(o_busy), 32'd1);
    for (int k = 1; k < 256; k++) begin
      if (k == ovr_k) begin
        i_wr   = 1'b1;
        i_data = 8'h55;
      end
      tick();
      i_wr = 1'b0;
      if (k == ovr_k) m_ovr = 1'b1;
      chk("clr_we", 32'(o_we), 32'd1);
      chk("clr_addr", 32'(o_addr), 32'(k));
      chk("clr_din", 32'(o_din), 32'h20);
      chk("clr_busy", 32'(o_busy), 32'd1);
      chk("clr_ovr", 32'(o_overrun), 32'(m_ovr));
    end
    tick();
    m_cursor = 8'h00;
    m_mode   = 0;
    chk("clr_end_we", 32'(o_we), 32'd0);
    chk("clr_end_busy", 32'(o_busy), 32'd0);
    chk_flags("clr_end");
  endtask

  task automatic send(input logic [7:0] b, input logic fc, input int ovr_k);
    logic       ew;
    logic [7:0] ea;
    logic [7:0] ed;
    logic       go_clear;
    logic       err_set;
    ew = 1'b0; ea = 8'h00; ed = 8'h00; go_clear = 1'b0; err_set = 1'b0;
    case (m_mode)
      0: begin
        if (b == 8'h1B) m_mode = 1;
        else if (b == 8'h0C) go_clear = 1'b1;
        else begin ew = 1'b1; ea = m_cursor; ed = b; m_cursor = m_cursor + 8'd1; end
      end
      1: begin
        m_mode = 0;
        if (b == 8'h41) m_mode = 2;
        else if (b == 8'h1B) begin ew = 1'b1; ea = m_cursor; ed = 8'h1B; m_cursor = m_cursor + 8'd1; end
        else err_set = 1'b1;
      end
      default: begin
        m_cursor = b;
        m_mode   = 0;
      end
    endcase
    m_err = err_set | (m_err & ~fc);
    m_ovr = m_ovr & ~fc;

    i_wr = 1'b1; i_data = b; i_flag_clr = fc;
    tick();
    i_wr = 1'b0; i_flag_clr = 1'b0;
    if (go_clear) begin
      sweep(ovr_k);
    end else begin
      chk("wr_we", 32'(o_we), 32'(ew));
      if (ew) begin
        chk("wr_addr", 32'(o_addr), 32'(ea));
        chk("wr_din", 32'(o_din), 32'(ed));
      end
      chk("wr_busy", 32'(o_busy), 32'd0);
      chk_flags("wr");
    end
  endtask

  task automatic gap(input int n, input logic fc);
    for (int j = 0; j < n; j++) begin
      i_flag_clr = fc;
      tick();
      i_flag_clr = 1'b0;
      if (fc) begin m_err = 1'b0; m_ovr = 1'b0; end
      chk("gap_we", 32'(o_we), 32'd0);
      chk_flags("gap");
    end
  endtask

  initial begin
    i_rst = 1'b0; i_wr = 1'b0; i_data = 8'h00; i_flag_clr = 1'b0;
    model_reset();
    tick();
    do_reset();

    // Text write
    send(8'h48, 1'b0, 0);
    send(8'h49, 1'b0, 0);
    chk("text_cursor", 32'(o_cursor), 32'd2);
    gap(2, 1'b0);

    // Set address then wrap
    send(8'h1B, 1'b0, 0);
    send(8'h41, 1'b0, 0);
    send(8'hFE, 1'b0, 0);
    send(8'h61, 1'b0, 0);
    send(8'h62, 1'b0, 0);
    send(8'h63, 1'b0, 0);
    chk("wrap_cursor", 32'(o_cursor), 32'h01);
    chk("wrap_err", 32'(o_err), 32'd0);

    // Escape handling
    send(8'h1B, 1'b0, 0);
    gap(3, 1'b0);
    send(8'h1B, 1'b0, 0);
    send(8'h1B, 1'b0, 0);
    send(8'h5A, 1'b0, 0);
    chk("esc_err_set", 32'(o_err), 32'd1);
    gap(1, 1'b1);
    chk("esc_err_clr", 32'(o_err), 32'd0);

    // Clear with overrun at sweep step 10
    send(8'h0C, 1'b0, 10);
    chk("ovr_flag", 32'(o_overrun), 32'd1);
    chk("ovr_cursor", 32'(o_cursor), 32'd0);
    gap(1, 1'b1);

    // Reset in the middle of a sweep
    send(8'h41, 1'b0, 0);
    i_wr = 1'b1; i_data = 8'h0C;
    tick();
    i_wr = 1'b0;
    for (int k = 1; k <= 8'h40; k++) tick();
    chk("mid_addr", 32'(o_addr), 32'h40);
    do_reset();
    tick();
    chk("mid_quiet_we", 32'(o_we), 32'd0);
    send(8'h41, 1'b0, 0);
    chk("mid_after_addr", 32'(o_addr), 32'd0);

    // Invalid escape coinciding with flag clear
    send(8'h1B, 1'b0, 0);
    send(8'h5A, 1'b1, 0);
    chk("set_wins_err", 32'(o_err), 32'd1);

    // Randomized byte stream
    for (int n = 0; n < 400; n++) begin
      int         r;
      logic [7:0] b;
      r = int'($urandom_range(0, 99));
      if (r < 15)      b = 8'h1B;
      else if (r < 25) b = 8'h41;
      else if (r < 27) b = 8'h0C;
      else             b = 8'($urandom);
      send(b, $urandom_range(0, 9) == 0,
           ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 255)) : 0);
      gap(int'($urandom_range(0, 2)), $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
